// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The optional stall counters are enabled by defining MEM_ARB_PERF_EN.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int PERF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the arbiter and its environment.
// Handshake: x_req is a level held until x_done (or, for fetch, a flush); x_done and
// mem_rdy are single-cycle pulses; mem_en is a single-cycle start pulse, one transaction at a time.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;

    // Arbiter side.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
        output i_rdata, i_done, if_stall, d_rdata, d_done, mem_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline and memory side.
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
        input  i_rdata, i_done, if_stall, d_rdata, d_done, mem_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the optional stall statistics.
module arb_sat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Define MEM_ARB_PERF_EN to add saturating per-requester stall counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output arb_state_t    state_dbg
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] i_stall_cnt,
    output logic [PERF_CNT_W-1:0] d_stall_cnt
`endif
);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              i_flush_q, i_flush_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_elig, d_elig;
    logic              if_stall, mem_stall;

    // A requester whose done pulse is showing this cycle is masked so it cannot re-grant on stale req.
    assign i_elig = bus.i_req & ~i_done_q;
    assign d_elig = bus.d_req & ~d_done_q;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        i_flush_d   = i_flush_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                i_flush_d = 1'b0;
                if (i_elig && (!d_elig || last_d_q)) begin
                    state_d    = BUSY_I;
                    last_d_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.i_addr;
                end else if (d_elig) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end
            end
            BUSY_I: begin
                // Once the fetch is dropped it stays dropped for this transaction.
                if (!bus.i_req) begin
                    i_flush_d = 1'b1;
                end
                if (bus.mem_rdy) begin
                    state_d = IDLE;
                    if (bus.i_req && !i_flush_q) begin
                        i_rdata_d = bus.mem_rdata;
                        i_done_d  = 1'b1;
                    end
                end
            end
            BUSY_D: begin
                if (bus.mem_rdy) begin
                    state_d  = IDLE;
                    d_done_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            i_flush_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            i_flush_q <= i_flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_stall  = bus.i_req & ~i_done_q;
    assign mem_stall = bus.d_req & ~d_done_q;

    assign bus.if_stall  = if_stall;
    assign bus.mem_stall = mem_stall;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign state_dbg     = state_q;

`ifdef MEM_ARB_PERF_EN
    arb_sat_counter #(.W(PERF_CNT_W)) u_i_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (if_stall),
        .count (i_stall_cnt)
    );

    arb_sat_counter #(.W(PERF_CNT_W)) u_d_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (mem_stall),
        .count (d_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory with variable latency,
// scoreboard queues for fetch/load results, grant log for ordering.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          cyc;
    } grant_t;

    logic       clk;
    logic       rst;
    arb_state_t state_dbg;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] i_stall_cnt;
    logic [15:0] d_stall_cnt;
`endif

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef MEM_ARB_PERF_EN
        ,
        .i_stall_cnt (i_stall_cnt),
        .d_stall_cnt (d_stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] i_exp_q[$];
    logic [15:0] d_exp_q[$];
    grant_t      glog[$];
    logic [15:0] mem [logic [15:0]];

    int  mem_lat    = 1;
    bit  mem_auto   = 1'b1;
    bit  stray_req  = 1'b0;
    logic [15:0] stray_data = 16'h0;
    int  rdy_cnt    = 0;
    int  i_done_cnt = 0;
    int  d_done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD;
    endfunction

    // memory responder: sole driver of mem_rdy / mem_rdata
    initial begin
        logic [15:0] a;
        logic [15:0] wd;
        logic        we;
        bus.mem_rdy   = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (stray_req) begin
                stray_req     = 1'b0;
                bus.mem_rdy   = 1'b1;
                bus.mem_rdata = stray_data;
                @(posedge clk);
                #1;
                bus.mem_rdy = 1'b0;
            end else if (mem_auto && bus.mem_en) begin
                a  = bus.mem_addr;
                we = bus.mem_we;
                wd = bus.mem_wdata;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.mem_rdy   = 1'b1;
                bus.mem_rdata = we ? 16'h0 : mem_rd(a);
                if (we) mem[a] = wd;
                rdy_cnt++;
                @(posedge clk);
                #1;
                bus.mem_rdy = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_en)
                glog.push_back('{addr: bus.mem_addr, we: bus.mem_we, wdata: bus.mem_wdata, cyc: cyc});
            if (bus.i_done) begin
                i_done_cnt++;
                if (i_exp_q.size() == 0) check("spurious_i_done", {31'd0, bus.i_done}, 32'd0);
                else check("i_rdata", {16'd0, bus.i_rdata}, {16'd0, i_exp_q.pop_front()});
            end
            if (bus.d_done) begin
                d_done_cnt++;
                if (d_exp_q.size() == 0) check("spurious_d_done", {31'd0, bus.d_done}, 32'd0);
                else check("d_rdata", {16'd0, bus.d_rdata}, {16'd0, d_exp_q.pop_front()});
            end
        end
    end

    // watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    // k = cycle index of done relative to the drive cycle; stall_n = stall cycles before done
    task automatic wait_done(input bit is_d, input int budget, output int k, output int stall_n);
        k = 0;
        stall_n = 0;
        forever begin
            @(negedge clk);
            if (is_d ? bus.d_done : bus.i_done) break;
            if (is_d ? bus.mem_stall : bus.if_stall) stall_n++;
            k++;
            if (k > budget) break;
        end
    endtask

    initial begin
        int k, sn, c0, n0, r0;
        logic [15:0] last_load;

        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 16'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
        mem[16'h0010] = 16'hA5A5;
        mem[16'h0040] = 16'h0F0F;
        mem[16'h0050] = 16'h7777;
        mem[16'h0200] = 16'h5A01;
        repeat (3) drive_cycle();

        // reset state
        @(negedge clk);
        check("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
        check("rst_dones",     {30'd0, bus.i_done, bus.d_done}, 32'd0);
        check("rst_mem_addr",  {16'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        check("rst_rdata",     {bus.i_rdata, bus.d_rdata}, 32'd0);
        check("rst_state",     {30'd0, state_dbg}, {30'd0, IDLE});
        drive_cycle();
        rst = 1'b0;
        repeat (2) drive_cycle();

        // lone fetch, latency 2
        mem_lat = 2;
        glog.delete();
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        i_exp_q.push_back(16'hA5A5);
        c0 = cyc;
        wait_done(1'b0, 20, k, sn);
        check("fetch_latency", k, 4);
        check("fetch_stall_cycles", sn, 4);
        check("fetch_stall_at_done", {31'd0, bus.if_stall}, 32'd0);
        check("fetch_grants", glog.size(), 1);
        if (glog.size() >= 1) begin
            check("fetch_mem_en_cyc", glog[0].cyc, c0 + 1);
            check("fetch_mem_addr", {16'd0, glog[0].addr}, 32'h0010);
            check("fetch_mem_we", {31'd0, glog[0].we}, 32'd0);
        end
        drive_cycle();
        bus.i_req = 1'b0;
        repeat (2) drive_cycle();

        // simultaneous requests, latency 1: D, I, D
        mem_lat = 1;
        glog.delete();
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        d_exp_q.push_back(16'h5A01);
        d_exp_q.push_back(16'h5A01);
        i_exp_q.push_back(16'h0F0F);
        wait_done(1'b1, 20, k, sn);
        check("best_case_load_latency", k, 3);
        wait_done(1'b0, 20, k, sn);
        check("fair_i_done_seen", {31'd0, bus.i_done}, 32'd1);
        drive_cycle();
        bus.i_req = 1'b0;
        wait_done(1'b1, 20, k, sn);
        check("second_d_done_seen", {31'd0, bus.d_done}, 32'd1);
        drive_cycle();
        bus.d_req = 1'b0;
        repeat (2) drive_cycle();
        check("sim_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            check("sim_grant0", {16'd0, glog[0].addr}, 32'h0200);
            check("sim_grant1", {16'd0, glog[1].addr}, 32'h0040);
            check("sim_grant2", {16'd0, glog[2].addr}, 32'h0200);
        end
        last_load = 16'h5A01;

        // store, latency 3
        mem_lat = 3;
        glog.delete();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0300; bus.d_wdata = 16'h1234;
        d_exp_q.push_back(last_load);
        wait_done(1'b1, 20, k, sn);
        check("store_latency", k, 5);
        drive_cycle();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        check("store_grants", glog.size(), 1);
        if (glog.size() >= 1) begin
            check("store_mem_we", {31'd0, glog[0].we}, 32'd1);
            check("store_mem_wdata", {16'd0, glog[0].wdata}, 32'h1234);
        end
        check("store_mem_written", {16'd0, mem_rd(16'h0300)}, 32'h1234);
        repeat (2) drive_cycle();

        // flush during fetch, latency 4
        mem_lat = 4;
        n0 = i_done_cnt;
        r0 = rdy_cnt;
        bus.i_req = 1'b1; bus.i_addr = 16'h0050;
        drive_cycle();
        drive_cycle();
        bus.i_req = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_no_i_done", i_done_cnt - n0, 0);
        check("flush_rdy_seen", rdy_cnt - r0, 1);
        check("flush_i_rdata_held", {16'd0, bus.i_rdata}, 32'h0F0F);
        check("flush_state_idle", {30'd0, state_dbg}, {30'd0, IDLE});
        drive_cycle();

        // reset mid-transaction, then a stray mem_rdy
        mem_auto = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        drive_cycle();
        drive_cycle();
        @(negedge clk);
        check("busy_d_before_rst", {30'd0, state_dbg}, {30'd0, BUSY_D});
        drive_cycle();
        rst = 1'b1;
        bus.d_req = 1'b0;
        drive_cycle();
        rst = 1'b0;
        n0 = d_done_cnt;
        k = glog.size();
        stray_data = 16'hBEEF;
        stray_req = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_no_d_done", d_done_cnt - n0, 0);
        check("rst_mid_no_mem_en", glog.size() - k, 0);
        check("rst_mid_state", {30'd0, state_dbg}, {30'd0, IDLE});
        check("rst_mid_rdata", {bus.i_rdata, bus.d_rdata}, 32'd0);
        check("rst_mid_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        mem_auto = 1'b1;
        drive_cycle();

`ifdef MEM_ARB_PERF_EN
        // stall counters
        check("perf_i_cnt_after_rst", {16'd0, i_stall_cnt}, 32'd0);
        mem_lat = 5;
        n0 = d_stall_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
        d_exp_q.push_back(16'h5A01);
        wait_done(1'b1, 30, k, sn);
        check("perf_stall_cycles", sn, 7);
        check("perf_d_delta", d_stall_cnt - n0, sn);
        drive_cycle();
        bus.d_req = 1'b0;
        repeat (2) drive_cycle();
        mem_auto = 1'b0;
        bus.d_req = 1'b1;
        repeat (70000) drive_cycle();
        @(negedge clk);
        check("perf_d_saturate", {16'd0, d_stall_cnt}, 32'hFFFF);
        drive_cycle();
        rst = 1'b1;
        bus.d_req = 1'b0;
        drive_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("perf_d_clear", {16'd0, d_stall_cnt}, 32'd0);
`endif

        check("sb_i_empty", i_exp_q.size(), 0);
        check("sb_d_empty", d_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage pipeline.
- Sequences one memory transaction at a time over a req/rdy handshake with variable memory latency.
- Produces per-requester stall signals that drive PC/IF-ID write enables alongside the load-use hazard stall.
- Data has priority, with a one-shot fairness rule so fetch cannot starve.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request level; held stable until i_done or flush.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word; valid when i_done=1.
- i_done  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  =i_req & ~i_done; feeds PC/IF-ID write hold.
- d_req  in  1  data request level; held stable until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid when d_done=1 and the transaction was a load.
- d_done  out  1  one-cycle completion pulse for data.
- mem_stall  out  1  =d_req & ~d_done.
- mem_en  out  1  one-cycle transaction start pulse to memory.
- mem_we  out  1  write enable, registered with mem_en.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_rdy.
- mem_rdy  in  1  one-cycle completion pulse from memory; at least 1 cycle after mem_en.

Behaviour:
- Reset values:
  - state=IDLE; last_d=0.
  - mem_en, mem_we, i_done, d_done = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant rule:
  - Eligible requester: req=1 and its done not asserted this cycle. A requester that has just completed is masked for that one cycle.
  - Both eligible and last_d=1: grant I. Otherwise, if d eligible, grant D; else if i eligible, grant I; else stay IDLE.
- On grant:
  - Next cycle: mem_en=1 for exactly one cycle, with mem_addr/mem_we/mem_wdata registered from the granted requester.
  - For I, mem_we=0.
  - last_d is set to 1 on a D grant and 0 on an I grant.
- BUSY_x: mem_en=0; mem_addr/mem_we/mem_wdata stay stable; wait for mem_rdy.
- On mem_rdy in BUSY_x:
  - Capture mem_rdata into x_rdata (loads/fetches only; d_rdata unchanged on a store).
  - Next cycle: x_done=1 for one cycle; state→IDLE.
  - Minimum turnaround: grant→mem_en 1 cycle, mem_rdy→done 1 cycle. Best-case load with 1-cycle memory latency: d_done 3 cycles after d_req rises.
- Flush: if i_req falls while in BUSY_I, the memory transaction still completes; i_done is suppressed and i_rdata is not updated. d_req must not drop mid-transaction; behaviour in that case is unspecified.
- mem_rdy while IDLE: ignored, no output change.
- Stall outputs are combinational from req and registered done; no combinational path from mem_rdy.
- Reset mid-transaction: immediate return to IDLE, all pulses cleared. A later mem_rdy for the aborted transaction is ignored.
- Exactly one transaction is outstanding at any time. mem_en never asserts while in BUSY_x.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds outputs i_stall_cnt and d_stall_cnt (16 bits each).
  - Each increments on every cycle its stall output is 1 and saturates at 16'hFFFF.
  - Both cleared by rst.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2), ADDR_W/DATA_W defaults, and a perf-counter width constant of 16.
- One natural sub-module, arb_sat_counter: 16-bit saturating counter with synchronous clear. It is instantiated twice under MEM_ARB_PERF_EN.

Test Plan:
- Lone fetch: i_req=1, i_addr=16'h0010, memory latency 2, mem_rdata=16'hA5A5. Expect mem_en 1 cycle after i_req with mem_addr=0010 and mem_we=0; then i_done with i_rdata=A5A5; if_stall high until the i_done cycle.
- Simultaneous requests: i_req and d_req (load, 16'h0200) rise together. Expect D granted first. After d_done, I is granted even though d_req stays high (last_d rule); then D is granted again.
- Store: d_we=1, d_addr=16'h0300, d_wdata=16'h1234. Expect mem_we=1 with mem_wdata=1234, d_done pulse, d_rdata unchanged.
- Flush during fetch: drop i_req in the 2nd cycle of BUSY_I. Expect no i_done pulse, i_rdata holds its old value, and the arbiter returns to IDLE after mem_rdy.
- Reset mid-transaction: assert rst during BUSY_D, then pulse mem_rdy after release. Expect all outputs at reset values, no d_done, state IDLE.
- With MEM_ARB_PERF_EN: hold d_req with memory latency 5. Expect d_stall_cnt to increase by exactly the number of cycles mem_stall is high. Force 70000 stall cycles and expect d_stall_cnt to saturate at FFFF.
